// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core (addu/subu/ori/lui/lw/sw/beq/j) with req/ack instruction and data ports.
// Define MIPS_TRAP_EN to build precise traps on illegal instructions and unaligned lw/sw.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_dout,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_din,
  output logic [3:0]  dmem_be,
  output logic        dmem_wren,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_dout,
  output logic        retire,
  output logic        trap
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  state_t      state_r;
  logic [31:0] pc_r, ir_r, a_r, b_r, imm_r, br_tgt_r, alu_out_r, mdr_r;
  logic [31:0] regs_r [0:31];
`ifdef MIPS_TRAP_EN
  logic [31:0] epc_r;
`endif

  logic [5:0]  op_s, fn_s;
  logic [4:0]  rs_s, rt_s, rd_s, wb_dst_s;
  logic [31:0] sext_s, imm_s, alu_s;
  logic        is_addu_s, is_subu_s, is_ori_s, is_lui_s, is_lw_s, is_sw_s, is_beq_s, is_j_s;
  logic        illegal_s, unaligned_s, trap_dec_s, trap_exec_s;

  assign op_s   = ir_r[31:26];
  assign rs_s   = ir_r[25:21];
  assign rt_s   = ir_r[20:16];
  assign rd_s   = ir_r[15:11];
  assign fn_s   = ir_r[5:0];
  assign sext_s = {{16{ir_r[15]}}, ir_r[15:0]};

  assign is_addu_s = (op_s == OP_RTYPE) && (fn_s == FN_ADDU);
  assign is_subu_s = (op_s == OP_RTYPE) && (fn_s == FN_SUBU);
  assign is_ori_s  = (op_s == OP_ORI);
  assign is_lui_s  = (op_s == OP_LUI);
  assign is_lw_s   = (op_s == OP_LW);
  assign is_sw_s   = (op_s == OP_SW);
  assign is_beq_s  = (op_s == OP_BEQ);
  assign is_j_s    = (op_s == OP_J);
  assign illegal_s = !(is_addu_s || is_subu_s || is_ori_s || is_lui_s ||
                       is_lw_s || is_sw_s || is_beq_s || is_j_s);

  assign wb_dst_s    = (op_s == OP_RTYPE) ? rd_s : rt_s;
  assign unaligned_s = (is_lw_s || is_sw_s) && (alu_s[1:0] != 2'b00);
  assign imem_addr   = pc_r;

`ifdef MIPS_TRAP_EN
  assign trap_dec_s  = illegal_s;
  assign trap_exec_s = unaligned_s;
`else
  assign trap_dec_s  = 1'b0;
  assign trap_exec_s = 1'b0;
  logic unused_trap_vector_s;
  assign unused_trap_vector_s = ^TRAP_VECTOR;
`endif

  // Immediate formatting and ALU result for the instruction held in ir
  always_comb begin
    imm_s = sext_s;
    alu_s = 32'd0;
    if (is_ori_s) begin
      imm_s = {16'h0000, ir_r[15:0]};
    end else if (is_lui_s) begin
      imm_s = {ir_r[15:0], 16'h0000};
    end else begin
      imm_s = sext_s;
    end
    case (1'b1)
      is_addu_s:          alu_s = a_r + b_r;
      is_subu_s:          alu_s = a_r - b_r;
      is_ori_s:           alu_s = a_r | imm_r;
      is_lui_s:           alu_s = imm_r;
      is_lw_s, is_sw_s:   alu_s = a_r + imm_r;
      default:            alu_s = 32'd0;
    endcase
  end

  // Sequencer: state, datapath registers, register file and registered port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      pc_r      <= RESET_PC;
      ir_r      <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      imm_r     <= 32'd0;
      br_tgt_r  <= 32'd0;
      alu_out_r <= 32'd0;
      mdr_r     <= 32'd0;
      for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
`ifdef MIPS_TRAP_EN
      epc_r     <= 32'd0;
`endif
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_addr <= 32'd0;
      dmem_din  <= 32'd0;
      dmem_be   <= 4'b0000;
      dmem_wren <= 1'b0;
      retire    <= 1'b0;
      trap      <= 1'b0;
    end else begin
      retire <= 1'b0;
      trap   <= 1'b0;
      case (state_r)
        S_FETCH: begin
          // req is low only in the first cycle after reset release
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir_r     <= imem_dout;
            pc_r     <= pc_r + 32'd4;
            imem_req <= 1'b0;
            state_r  <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r      <= regs_r[rs_s];
          b_r      <= regs_r[rt_s];
          imm_r    <= imm_s;
          br_tgt_r <= pc_r + {sext_s[29:0], 2'b00};
          if (trap_dec_s) begin
`ifdef MIPS_TRAP_EN
            epc_r    <= pc_r - 32'd4;
`endif
            pc_r     <= TRAP_VECTOR;
            trap     <= 1'b1;
            imem_req <= 1'b1;
            state_r  <= S_FETCH;
          end else begin
            state_r  <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out_r <= alu_s;
          if (is_beq_s || is_j_s || illegal_s) begin
            if (is_beq_s && (a_r == b_r)) begin
              pc_r <= br_tgt_r;
            end else if (is_j_s) begin
              pc_r <= {pc_r[31:28], ir_r[25:0], 2'b00};
            end else begin
              pc_r <= pc_r;
            end
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state_r  <= S_FETCH;
          end else if (trap_exec_s) begin
`ifdef MIPS_TRAP_EN
            epc_r    <= pc_r - 32'd4;
`endif
            pc_r     <= TRAP_VECTOR;
            trap     <= 1'b1;
            imem_req <= 1'b1;
            state_r  <= S_FETCH;
          end else if (is_lw_s || is_sw_s) begin
            dmem_req  <= 1'b1;
            dmem_addr <= {alu_s[31:2], 2'b00};
            dmem_din  <= b_r;
            dmem_be   <= is_sw_s ? 4'b1111 : 4'b0000;
            dmem_wren <= is_sw_s;
            state_r   <= S_MEM;
          end else begin
            state_r   <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_be   <= 4'b0000;
            dmem_wren <= 1'b0;
            if (dmem_wren) begin
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state_r  <= S_FETCH;
            end else begin
              mdr_r    <= dmem_dout;
              state_r  <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dst_s != 5'd0) regs_r[wb_dst_s] <= is_lw_s ? mdr_r : alu_out_r;
          retire   <= 1'b1;
          imem_req <= 1'b1;
          state_r  <= S_FETCH;
        end
        default: begin
          imem_req <= 1'b1;
          state_r  <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Randomized scoreboard bench for mips_multicycle: an ISA-level model predicts fetch addresses,
// data accesses and per-instruction retire/trap latency; monitors compare against the DUT.
module tb_mips_multicycle;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0180;
  localparam int          N_INSTR     = 250;
`ifdef MIPS_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack, dmem_req, dmem_wren, dmem_ack, retire, trap;
  logic [31:0] imem_addr, imem_dout, dmem_addr, dmem_din, dmem_dout;
  logic [3:0]  dmem_be;

  mips_multicycle #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_dout(imem_dout),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_be(dmem_be),
    .dmem_wren(dmem_wren), .dmem_ack(dmem_ack), .dmem_dout(dmem_dout),
    .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wren; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } dacc_t;
  typedef struct packed { logic is_trap; logic [31:0] lat; } evt_t;

  logic [31:0] imem     [logic [31:0]];
  logic [31:0] dut_dmem [logic [31:0]];
  logic [31:0] ref_dmem [logic [31:0]];
  logic [31:0] rf [32];
  logic [31:0] exp_fetch_q [$];
  dacc_t       exp_dacc_q [$];
  evt_t        exp_evt_q [$];
  int          iwait_q [$];
  int          dwait_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          hold_loads = 1'b0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm, off;
    int          k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    off = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom_range(0, 63) * 4);
    k   = $urandom_range(0, 19);
    case (k)
      0, 1, 2:    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      3, 4:       return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      5, 6:       return {6'h0D, rs, rt, imm};
      7:          return {6'h0F, 5'd0, rt, imm};
      8, 9, 10:   return {6'h23, 5'd0, rt, off};
      11, 12, 13: return {6'h2B, 5'd0, rt, off};
      14, 15:     return {6'h04, rs, rt, 16'($urandom_range(0, 4))};
      16:         return {6'h02, 26'($urandom)};
      17:         return {6'h3F, 26'($urandom)};
      18:         return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      default:    return {6'h0D, rs, rt, imm};
    endcase
  endfunction

  // ISA-level reference: executes N_INSTR instructions and queues every expected observation
  task automatic build_program();
    logic [31:0] pc, ins, npc, a, b, ea, sx, res;
    logic [4:0]  dst;
    int          iw, dw, lat;
    bit          ill, tr;
    imem[32'h00] = 32'h3401_00FF;  // ori  r1,r0,0xFF
    imem[32'h04] = 32'h0021_1021;  // addu r2,r1,r1
    imem[32'h08] = 32'hAC02_0008;  // sw   r2,8(r0)
    imem[32'h0C] = 32'h8C03_0008;  // lw   r3,8(r0)
    imem[32'h10] = 32'h1001_0004;  // beq  r0,r1,+4 (not taken)
    imem[32'h14] = 32'h0021_0021;  // addu r0,r1,r1
    imem[32'h18] = 32'hAC03_000C;  // sw   r3,12(r0)
    imem[32'h1C] = 32'hAC00_0010;  // sw   r0,16(r0)
    imem[32'h20] = 32'h1021_0001;  // beq  r1,r1,+1 (taken)
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    pc = RESET_PC;
    for (int n = 0; n < N_INSTR; n++) begin
      if (!imem.exists(pc)) imem[pc] = gen_instr();
      ins = imem[pc];
      iw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      iwait_q.push_back(iw);
      exp_fetch_q.push_back(pc);
      a   = rf[ins[25:21]];
      b   = rf[ins[20:16]];
      sx  = {{16{ins[15]}}, ins[15:0]};
      npc = pc + 32'd4;
      res = 32'd0; dst = 5'd0; lat = 3; ill = 1'b0; tr = 1'b0;
      case (ins[31:26])
        6'h00: begin
          if (ins[5:0] == 6'h21)      begin res = a + b; dst = ins[15:11]; lat = 4; end
          else if (ins[5:0] == 6'h23) begin res = a - b; dst = ins[15:11]; lat = 4; end
          else ill = 1'b1;
        end
        6'h0D: begin res = a | {16'h0, ins[15:0]}; dst = ins[20:16]; lat = 4; end
        6'h0F: begin res = {ins[15:0], 16'h0};     dst = ins[20:16]; lat = 4; end
        6'h23, 6'h2B: begin
          ea = a + sx;
          if (TRAP_BUILD && (ea[1:0] != 2'b00)) begin
            tr = 1'b1; lat = 3;
          end else begin
            dw = (pc < 32'h20) ? 3 : (($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            dwait_q.push_back(dw);
            ea = {ea[31:2], 2'b00};
            if (ins[31:26] == 6'h2B) begin
              exp_dacc_q.push_back('{1'b1, ea, b, 4'hF});
              ref_dmem[ea] = b;
              lat = 4 + dw;
            end else begin
              exp_dacc_q.push_back('{1'b0, ea, 32'h0, 4'h0});
              res = ref_dmem.exists(ea) ? ref_dmem[ea] : mem_init(ea);
              dst = ins[20:16];
              lat = 5 + dw;
            end
          end
        end
        6'h04: begin if (a == b) npc = npc + (sx << 2); lat = 3; end
        6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; lat = 3; end
        default: ill = 1'b1;
      endcase
      if (ill) begin
        if (TRAP_BUILD) begin tr = 1'b1; lat = 2; end
        else lat = 3;
      end
      if (tr) npc = TRAP_VECTOR;
      else if (dst != 5'd0) rf[dst] = res;
      exp_evt_q.push_back('{tr, 32'(lat + iw)});
      pc = npc;
    end
  endtask

  initial begin : cycle_counter
    forever begin
      @(negedge clk);
      cyc++;
    end
  end

  initial begin : imem_resp
    int cnt;
    cnt = -1; imem_ack = 1'b0; imem_dout = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || !imem_req) begin
        cnt = -1;
        imem_ack  = ($urandom_range(0, 3) == 0);
        imem_dout = $urandom;
      end else begin
        if (cnt < 0) cnt = (iwait_q.size() > 0) ? iwait_q.pop_front() : 0;
        if (cnt == 0) begin
          imem_ack  = 1'b1;
          imem_dout = imem.exists(imem_addr) ? imem[imem_addr] : 32'd0;
          cnt = -1;
        end else begin
          imem_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  initial begin : dmem_resp
    int cnt;
    cnt = -1; dmem_ack = 1'b0; dmem_dout = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_n || !dmem_req) begin
        cnt = -1;
        dmem_ack  = rst_n && ($urandom_range(0, 3) == 0);
        dmem_dout = $urandom;
      end else begin
        if (cnt < 0) cnt = (dwait_q.size() > 0) ? dwait_q.pop_front() : 0;
        if (hold_loads && !dmem_wren) begin
          dmem_ack = 1'b0;
        end else if (cnt == 0) begin
          dmem_ack = 1'b1;
          if (dmem_wren) dut_dmem[dmem_addr] = dmem_din;
          else dmem_dout = dut_dmem.exists(dmem_addr) ? dut_dmem[dmem_addr] : mem_init(dmem_addr);
          cnt = -1;
        end else begin
          dmem_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  initial begin : fetch_mon
    logic [31:0] held, e;
    bit          was;
    was = 1'b0; held = 32'd0;
    forever begin
      @(negedge clk); #2;
      if (chk_en && rst_n && imem_req) begin
        if (was) check("imem_addr_stable", imem_addr, held);
        held = imem_addr; was = 1'b1;
        if (imem_ack) begin
          was = 1'b0;
          if (exp_fetch_q.size() > 0) begin
            e = exp_fetch_q.pop_front();
            check("fetch_addr", imem_addr, e);
          end
        end
      end else was = 1'b0;
    end
  end

  initial begin : dmem_mon
    dacc_t held, e;
    bit    was;
    was = 1'b0; held = '0;
    forever begin
      @(negedge clk); #2;
      if (chk_en && rst_n && dmem_req) begin
        if (was) begin
          check("dmem_addr_stable", dmem_addr, held.addr);
          check("dmem_din_stable", dmem_din, held.data);
          check("dmem_be_stable", 32'(dmem_be), 32'(held.be));
          check("dmem_wren_stable", 32'(dmem_wren), 32'(held.wren));
        end
        held = '{dmem_wren, dmem_addr, dmem_din, dmem_be}; was = 1'b1;
        if (dmem_ack) begin
          was = 1'b0;
          if (exp_dacc_q.size() > 0) begin
            e = exp_dacc_q.pop_front();
            check("dmem_wren", 32'(dmem_wren), 32'(e.wren));
            check("dmem_addr", dmem_addr, e.addr);
            check("dmem_be", 32'(dmem_be), 32'(e.be));
            if (e.wren) check("dmem_din", dmem_din, e.data);
          end
        end
      end else was = 1'b0;
    end
  end

  initial begin : evt_mon
    int   prev;
    evt_t e;
    prev = -1;
    forever begin
      @(negedge clk); #2;
      if (!chk_en || !rst_n) begin
        prev = -1;
      end else begin
        if (prev < 0 && imem_req) prev = cyc;
        if (retire || trap) begin
          if (exp_evt_q.size() > 0) begin
            e = exp_evt_q.pop_front();
            check("trap_pulse", 32'(trap), 32'(e.is_trap));
            check("retire_pulse", 32'(retire), 32'(!e.is_trap));
            check("latency", 32'(cyc - prev), e.lat);
          end
          prev = cyc;
        end
      end
    end
  end

  initial begin : main
    bit found;
    build_program();
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_wren", 32'(dmem_wren), 32'd0);
    check("rst_dmem_be", 32'(dmem_be), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", imem_addr, RESET_PC);
    rst_n = 1'b1;
    for (int t = 0; t < 30000 && exp_evt_q.size() > 0; t++) @(negedge clk);
    check("events_drained", 32'(exp_evt_q.size()), 32'd0);
    chk_en = 1'b0;
    check("dacc_drained", 32'(exp_dacc_q.size()), 32'd0);

    // Reset while a load is stalled waiting for dmem_ack
    hold_loads = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk); #2;
      if (dmem_req && !dmem_wren) found = 1'b1;
    end
    check("stalled_lw_reached", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_dmem_req", 32'(dmem_req), 32'd0);
    check("midreset_imem_req", 32'(imem_req), 32'd0);
    check("midreset_dmem_be", 32'(dmem_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; hold_loads = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk); #2;
      if (imem_req) found = 1'b1;
    end
    check("post_reset_fetch_seen", 32'(found), 32'd1);
    check("post_reset_fetch_addr", imem_addr, RESET_PC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
